// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC78H90 scan scheduler and its frame engine.
// Channel numbers name the board wiring so callers need not hard-code indices.
package adc_pkg;

  localparam int ADC_CH_W   = 3;
  localparam int ADC_DATA_W = 12;

  localparam logic [ADC_CH_W-1:0] ADC_CH_VFWD   = 3'd4;
  localparam logic [ADC_CH_W-1:0] ADC_CH_SUPPLY = 3'd5;

  typedef logic [ADC_CH_W-1:0]   adc_chan_t;
  typedef logic [ADC_DATA_W-1:0] adc_data_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_ISSUE,
    S_WAIT,
    S_FLUSH_ISSUE,
    S_FLUSH_WAIT,
    S_GAP
  } sched_state_t;

endpackage

// File: rtl/adc_scan_scheduler_if.sv
// Handshake between the scan scheduler (master) and the SPI frame engine (slave).
// The engine returns the previous frame's conversion with frame_done.
interface adc_scan_scheduler_if;
  import adc_pkg::*;

  logic      frame_start;
  adc_chan_t frame_addr;
  logic      frame_done;
  adc_data_t frame_data;

  modport master (
    output frame_start,
    output frame_addr,
    input  frame_done,
    input  frame_data
  );

  modport slave (
    input  frame_start,
    input  frame_addr,
    output frame_done,
    output frame_data
  );

endinterface

// File: rtl/adc_chan_picker.sv
// Finds the lowest set mask bit at or above a pointer; purely combinational.
module adc_chan_picker
  import adc_pkg::*;
#(
  parameter int NUM_CH = 8
) (
  input  logic [NUM_CH-1:0] mask,
  input  adc_chan_t         ptr,
  output adc_chan_t         idx,
  output logic              found
);

  // Scanning downward lets the lowest qualifying bit win the last assignment.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(ptr))) begin
        found = 1'b1;
        idx   = adc_chan_t'(i);
      end
    end
  end

endmodule

// File: rtl/adc_scan_scheduler.sv
// Round-robin sweep plus urgent one-shot conversions over the ADC78H90 frame engine,
// tracking the one-frame result pipeline and flushing it at the end of each sequence.
module adc_scan_scheduler
  import adc_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int SCAN_GAP = 1024
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        scan_enable,
  input  logic [NUM_CH-1:0]           chan_mask,
  input  logic                        urgent_req,
  input  adc_chan_t                   urgent_chan,
  output logic                        urgent_ack,
  adc_scan_scheduler_if.master        frame,
  output logic                        result_valid,
  output adc_chan_t                   result_chan,
  output adc_data_t                   result_data,
  output logic                        result_urgent,
  output logic                        sweep_done
);

  localparam logic [15:0] GAP_LAST = 16'(SCAN_GAP - 1);

  sched_state_t      state, next_state;
  logic [NUM_CH-1:0] sweep_mask;
  adc_chan_t         rr_ptr;
  adc_chan_t         sel_chan;
  logic              sel_urgent;
  adc_chan_t         prev_chan;
  logic              prev_urgent;
  logic              prev_valid;
  adc_chan_t         addr_q;
  logic [15:0]       gap_cnt;
  logic              sweep_active;
  logic              sweep_pend;
  adc_chan_t         pick_idx;
  logic              pick_found;
  logic              start_seq;
  logic              start_c;
  logic              ack_c;

  adc_chan_picker #(.NUM_CH(NUM_CH)) u_picker (
    .mask  (sweep_mask),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign start_seq         = (scan_enable && (chan_mask != '0)) || urgent_req;
  assign frame.frame_start = start_c;
  assign frame.frame_addr  = addr_q;
  assign urgent_ack        = ack_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    start_c    = 1'b0;
    ack_c      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_seq) next_state = S_PICK;
      end
      S_PICK: begin
        // An urgent request dropped before PICK leaves nothing to send; close out cleanly.
        if (urgent_req || pick_found) next_state = S_ISSUE;
        else if (prev_valid)          next_state = S_FLUSH_ISSUE;
        else                          next_state = S_IDLE;
      end
      S_ISSUE: begin
        start_c    = 1'b1;
        ack_c      = sel_urgent;
        next_state = S_WAIT;
      end
      S_WAIT: begin
        if (frame.frame_done) begin
          if (urgent_req || ((sweep_mask != '0) && scan_enable)) next_state = S_PICK;
          else                                                    next_state = S_FLUSH_ISSUE;
        end
      end
      S_FLUSH_ISSUE: begin
        start_c    = 1'b1;
        next_state = S_FLUSH_WAIT;
      end
      S_FLUSH_WAIT: begin
        if (frame.frame_done) next_state = scan_enable ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (urgent_req)                next_state = S_PICK;
        else if (gap_cnt == GAP_LAST)  next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sweep_mask    <= '0;
      rr_ptr        <= '0;
      sel_chan      <= '0;
      sel_urgent    <= 1'b0;
      prev_chan     <= '0;
      prev_urgent   <= 1'b0;
      prev_valid    <= 1'b0;
      addr_q        <= '0;
      gap_cnt       <= '0;
      sweep_active  <= 1'b0;
      sweep_pend    <= 1'b0;
      result_valid  <= 1'b0;
      result_chan   <= '0;
      result_data   <= '0;
      result_urgent <= 1'b0;
      sweep_done    <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      sweep_pend   <= 1'b0;
      sweep_done   <= sweep_pend;
      case (state)
        S_IDLE: begin
          // The mask is captured once so mid-sweep edits only affect the next sweep.
          if (start_seq) begin
            sweep_mask   <= scan_enable ? chan_mask : '0;
            rr_ptr       <= '0;
            sweep_active <= scan_enable && (chan_mask != '0);
          end
        end
        S_PICK: begin
          if (urgent_req) begin
            sel_chan   <= urgent_chan;
            sel_urgent <= 1'b1;
            addr_q     <= urgent_chan;
          end else if (pick_found) begin
            sel_chan             <= pick_idx;
            sel_urgent           <= 1'b0;
            addr_q               <= pick_idx;
            sweep_mask[pick_idx] <= 1'b0;
            rr_ptr               <= pick_idx + 3'd1;
          end else begin
            addr_q <= prev_chan;
          end
        end
        S_WAIT: begin
          if (frame.frame_done) begin
            if (prev_valid) begin
              result_valid  <= 1'b1;
              result_chan   <= prev_chan;
              result_data   <= frame.frame_data;
              result_urgent <= prev_urgent;
            end
            prev_chan   <= sel_chan;
            prev_urgent <= sel_urgent;
            prev_valid  <= 1'b1;
          end
        end
        S_FLUSH_WAIT: begin
          // The flush frame's own conversion is dropped; only prev_chan's result is used.
          if (frame.frame_done) begin
            result_valid  <= prev_valid;
            result_chan   <= prev_chan;
            result_data   <= frame.frame_data;
            result_urgent <= prev_urgent;
            prev_valid    <= 1'b0;
            sweep_pend    <= sweep_active && (sweep_mask == '0);
            sweep_active  <= 1'b0;
            gap_cnt       <= '0;
          end
        end
        S_GAP: begin
          if (urgent_req) begin
            sweep_mask   <= '0;
            sweep_active <= 1'b0;
            gap_cnt      <= '0;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler with a behavioural frame engine and
// scoreboard queues for issued frames and tagged results.
module tb_adc_scan_scheduler;
  import adc_pkg::*;

  localparam int TB_GAP    = 20;
  localparam int FRAME_LEN = 6;

  logic      clock;
  logic      reset;
  logic      scan_enable;
  logic [7:0] chan_mask;
  logic      urgent_req;
  adc_chan_t urgent_chan;
  logic      urgent_ack;
  logic      result_valid;
  adc_chan_t result_chan;
  adc_data_t result_data;
  logic      result_urgent;
  logic      sweep_done;

  adc_scan_scheduler_if frame_bus ();

  adc_scan_scheduler #(.NUM_CH(8), .SCAN_GAP(TB_GAP)) dut (
    .clock         (clock),
    .reset         (reset),
    .scan_enable   (scan_enable),
    .chan_mask     (chan_mask),
    .urgent_req    (urgent_req),
    .urgent_chan   (urgent_chan),
    .urgent_ack    (urgent_ack),
    .frame         (frame_bus.master),
    .result_valid  (result_valid),
    .result_chan   (result_chan),
    .result_data   (result_data),
    .result_urgent (result_urgent),
    .sweep_done    (sweep_done)
  );

  int checks = 0;
  int errors = 0;
  int sweep_cnt = 0;
  int start_cnt = 0;
  logic rv_d = 1'b0;

  logic [3:0]  exp_frames[$];
  logic [15:0] exp_results[$];

  logic      eng_busy;
  int        eng_cnt;
  adc_chan_t eng_addr;
  adc_chan_t eng_last;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_frame(input adc_chan_t ch, input logic urg);
    exp_frames.push_back({urg, ch});
  endfunction

  function automatic void push_result(input adc_chan_t ch, input logic urg);
    exp_results.push_back({urg, ch, 12'h100 + {9'd0, ch}});
  endfunction

  // Frame engine model: returns 0x100 + the previous frame's address.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      eng_busy             <= 1'b0;
      eng_cnt              <= 0;
      eng_addr             <= '0;
      eng_last             <= '0;
      frame_bus.frame_done <= 1'b0;
      frame_bus.frame_data <= '0;
    end else begin
      frame_bus.frame_done <= 1'b0;
      if (eng_busy) begin
        if (eng_cnt == FRAME_LEN - 1) begin
          eng_busy             <= 1'b0;
          frame_bus.frame_done <= 1'b1;
          frame_bus.frame_data <= 12'h100 + {9'd0, eng_last};
          eng_last             <= eng_addr;
        end else begin
          eng_cnt <= eng_cnt + 1;
        end
      end else if (frame_bus.frame_start) begin
        eng_busy <= 1'b1;
        eng_cnt  <= 0;
        eng_addr <= frame_bus.frame_addr;
      end
    end
  end

  always @(negedge clock) begin
    if (frame_bus.frame_start) begin
      start_cnt++;
      if (exp_frames.size() == 0)
        check_output("frame_expected", 32'(exp_frames.size()), 32'd1);
      else
        check_output("frame", {urgent_ack, frame_bus.frame_addr}, exp_frames.pop_front());
    end
    if (frame_bus.frame_done)
      check_output("addr_stable", frame_bus.frame_addr, eng_addr);
    if (result_valid) begin
      if (exp_results.size() == 0)
        check_output("result_expected", 32'(exp_results.size()), 32'd1);
      else
        check_output("result", {result_urgent, result_chan, result_data}, exp_results.pop_front());
    end
    if (sweep_done) begin
      sweep_cnt++;
      check_output("sweep_done_after_result", rv_d, 1'b1);
    end
    rv_d = result_valid;
  end

  task automatic wait_frame_addr(input adc_chan_t ch, input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (frame_bus.frame_start && (frame_bus.frame_addr == ch)) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_sweep_done(input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (sweep_done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_urgent_ack(input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (urgent_ack) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (dut.state == S_IDLE && !eng_busy && exp_frames.size() == 0 && exp_results.size() == 0) begin
        seen = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clock);
  endtask

  initial begin
    logic seen;
    int   n;
    int   s;
    reset       = 1'b1;
    scan_enable = 1'b0;
    chan_mask   = 8'h00;
    urgent_req  = 1'b0;
    urgent_chan = '0;
    repeat (3) @(negedge clock);
    check_output("rst_frame", {frame_bus.frame_start, urgent_ack, frame_bus.frame_addr}, 32'd0);
    check_output("rst_result", {result_valid, result_urgent, result_chan, result_data}, 32'd0);
    check_output("rst_sweep_done", sweep_done, 32'd0);
    reset = 1'b0;

    // Basic sweep over channels 0, 2, 4, 5.
    push_frame(3'd0, 1'b0); push_frame(3'd2, 1'b0); push_frame(ADC_CH_VFWD, 1'b0);
    push_frame(ADC_CH_SUPPLY, 1'b0); push_frame(ADC_CH_SUPPLY, 1'b0);
    push_result(3'd0, 1'b0); push_result(3'd2, 1'b0); push_result(ADC_CH_VFWD, 1'b0);
    push_result(ADC_CH_SUPPLY, 1'b0);
    chan_mask   = 8'b0011_0101;
    scan_enable = 1'b1;
    wait_sweep_done(400, seen);
    check_output("sweep1_done_seen", seen, 1'b1);

    // Second sweep with an urgent VFWD conversion while channel 2 is in flight.
    push_frame(3'd0, 1'b0); push_frame(3'd2, 1'b0); push_frame(ADC_CH_VFWD, 1'b1);
    push_frame(ADC_CH_VFWD, 1'b0); push_frame(ADC_CH_SUPPLY, 1'b0); push_frame(ADC_CH_SUPPLY, 1'b0);
    push_result(3'd0, 1'b0); push_result(3'd2, 1'b0); push_result(ADC_CH_VFWD, 1'b1);
    push_result(ADC_CH_VFWD, 1'b0); push_result(ADC_CH_SUPPLY, 1'b0);
    n = 0;
    for (int i = 0; i < TB_GAP + 50; i++) begin
      @(negedge clock);
      n++;
      if (frame_bus.frame_start) break;
    end
    check_output("gap_len", n, TB_GAP + 1);
    wait_frame_addr(3'd2, 200, seen);
    check_output("sweep2_ch2_seen", seen, 1'b1);
    urgent_chan = ADC_CH_VFWD;
    urgent_req  = 1'b1;
    wait_urgent_ack(200, seen);
    urgent_req = 1'b0;
    check_output("urgent_ack_seen", seen, 1'b1);
    wait_sweep_done(400, seen);
    check_output("sweep2_done_seen", seen, 1'b1);
    scan_enable = 1'b0;
    wait_idle(400, seen);
    check_output("sweep2_idle", seen, 1'b1);
    check_output("sweep_count_2", sweep_cnt, 2);

    // Urgent conversion from idle: one frame plus its flush.
    s = start_cnt;
    push_frame(3'd6, 1'b1); push_frame(3'd6, 1'b0);
    push_result(3'd6, 1'b1);
    urgent_chan = 3'd6;
    urgent_req  = 1'b1;
    wait_urgent_ack(50, seen);
    urgent_req = 1'b0;
    check_output("idle_urgent_ack", seen, 1'b1);
    wait_idle(200, seen);
    check_output("idle_urgent_idle", seen, 1'b1);
    check_output("idle_urgent_frames", start_cnt - s, 2);
    check_output("sweep_count_3", sweep_cnt, 2);

    // Disable mid-sweep after the third frame_done.
    for (int c = 0; c < 4; c++) begin
      push_frame(adc_chan_t'(c), 1'b0);
      push_result(adc_chan_t'(c), 1'b0);
    end
    push_frame(3'd3, 1'b0);
    chan_mask   = 8'hFF;
    scan_enable = 1'b1;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (frame_bus.frame_done) n++;
      if (n == 3) break;
    end
    check_output("disable_three_done", n, 3);
    @(negedge clock);
    scan_enable = 1'b0;
    wait_idle(400, seen);
    check_output("disable_idle", seen, 1'b1);
    check_output("sweep_count_4", sweep_cnt, 2);

    // Empty mask with scanning enabled issues nothing.
    s = start_cnt;
    chan_mask   = 8'h00;
    scan_enable = 1'b1;
    repeat (10000) @(negedge clock);
    check_output("mask0_no_frames", start_cnt - s, 0);
    scan_enable = 1'b0;

    // Mask edited mid-sweep applies to the following sweep only.
    push_frame(3'd0, 1'b0); push_frame(3'd1, 1'b0); push_frame(3'd1, 1'b0);
    push_result(3'd0, 1'b0); push_result(3'd1, 1'b0);
    chan_mask   = 8'h03;
    scan_enable = 1'b1;
    wait_frame_addr(3'd0, 50, seen);
    check_output("maskchg_first_frame", seen, 1'b1);
    chan_mask = 8'h80;
    wait_sweep_done(400, seen);
    check_output("maskchg_sweep_a", seen, 1'b1);
    push_frame(3'd7, 1'b0); push_frame(3'd7, 1'b0);
    push_result(3'd7, 1'b0);
    wait_sweep_done(400, seen);
    check_output("maskchg_sweep_b", seen, 1'b1);
    scan_enable = 1'b0;
    wait_idle(400, seen);
    check_output("maskchg_idle", seen, 1'b1);
    check_output("sweep_count_6", sweep_cnt, 4);

    // Reset while a frame is in flight.
    push_frame(3'd1, 1'b0);
    chan_mask   = 8'h06;
    scan_enable = 1'b1;
    wait_frame_addr(3'd1, 50, seen);
    check_output("rstmid_frame_seen", seen, 1'b1);
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check_output("rstmid_frame", {frame_bus.frame_start, urgent_ack, frame_bus.frame_addr}, 32'd0);
    check_output("rstmid_result", {result_valid, result_urgent, result_chan, result_data}, 32'd0);
    check_output("rstmid_sweep_done", sweep_done, 32'd0);
    push_frame(3'd1, 1'b0); push_frame(3'd2, 1'b0); push_frame(3'd2, 1'b0);
    push_result(3'd1, 1'b0); push_result(3'd2, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    wait_sweep_done(400, seen);
    check_output("rstmid_sweep_done_seen", seen, 1'b1);
    scan_enable = 1'b0;
    wait_idle(400, seen);
    check_output("rstmid_idle", seen, 1'b1);
    check_output("sweep_count_7", sweep_cnt, 5);

    check_output("frames_drained", exp_frames.size(), 0);
    check_output("results_drained", exp_results.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
